// File: rtl/transform_vertex_sequencer.sv
// Splits transform setup beats into three vertex beats, each paired with the model and camera transforms.
// Optional triangle statistics counter is built when SEQ_STATS_EN is defined.
package transform_vertex_sequencer_pkg;
    localparam int unsigned COORD_W  = 16;
    localparam int unsigned COLOR_W  = 12;
    localparam int unsigned XF_ELEMS = 12;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] z;
        logic [COLOR_W-1:0] color;
    } vertex_t;

    typedef struct packed {
        vertex_t v0;
        vertex_t v1;
        vertex_t v2;
    } triangle_t;

    typedef struct packed {
        logic [XF_ELEMS-1:0][COORD_W-1:0] m;
    } transform_t;

    typedef struct packed {
        triangle_t  triangle;
        transform_t model_transform;
        logic       model_transform_valid;
        transform_t camera_transform;
        logic       camera_transform_valid;
    } transform_setup_t;
endpackage

module transform_vertex_sequencer
    import transform_vertex_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  transform_setup_t setup_in,
    input  logic             frame_clear,
    output logic             vtx_valid,
    input  logic             vtx_ready,
    output vertex_t          vtx_out,
    output logic [1:0]       vtx_idx,
    output logic             vtx_last,
    output transform_t       model_out,
    output transform_t       camera_out,
    output logic             camera_loaded,
    output logic             err_no_cam,
    output logic [CNT_W-1:0] tri_count
);

    typedef enum logic [1:0] {IDLE, EMIT_V0, EMIT_V1, EMIT_V2} state_e;

    state_e     state_q;
    transform_t cam_q;
    triangle_t  tri_q;
    logic       camera_loaded_q;
    logic       err_q;
    logic       vtx_valid_q;
    vertex_t    vtx_out_q;
    logic [1:0] vtx_idx_q;
    logic       vtx_last_q;
    transform_t model_out_q;
    transform_t camera_out_q;

    logic       accept;
    logic       cam_take;
    logic       tri_take;
    logic       tri_drop;
    logic       vtx_hs;
    transform_t cam_d;

    assign in_ready = (state_q == IDLE) && !rst;

    // A triangle may use a camera arriving on the same beat.
    always_comb begin
        accept   = in_valid && in_ready;
        cam_take = accept && setup_in.camera_transform_valid;
        tri_take = accept && setup_in.model_transform_valid
                   && (camera_loaded_q || setup_in.camera_transform_valid);
        tri_drop = accept && setup_in.model_transform_valid
                   && !camera_loaded_q && !setup_in.camera_transform_valid;
        vtx_hs   = vtx_valid_q && vtx_ready;
        cam_d    = setup_in.camera_transform_valid ? setup_in.camera_transform : cam_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cam_q           <= '0;
            tri_q           <= '0;
            camera_loaded_q <= 1'b0;
            err_q           <= 1'b0;
            vtx_valid_q     <= 1'b0;
            vtx_out_q       <= '0;
            vtx_idx_q       <= 2'd0;
            vtx_last_q      <= 1'b0;
            model_out_q     <= '0;
            camera_out_q    <= '0;
        end else begin
            // A camera accept overrides a coincident frame_clear.
            if (cam_take) begin
                cam_q           <= setup_in.camera_transform;
                camera_loaded_q <= 1'b1;
            end else if (frame_clear) begin
                camera_loaded_q <= 1'b0;
            end

            if (tri_drop) begin
                err_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (tri_take) begin
                        tri_q        <= setup_in.triangle;
                        model_out_q  <= setup_in.model_transform;
                        camera_out_q <= cam_d;
                        vtx_valid_q  <= 1'b1;
                        vtx_out_q    <= setup_in.triangle.v0;
                        vtx_idx_q    <= 2'd0;
                        vtx_last_q   <= 1'b0;
                        state_q      <= EMIT_V0;
                    end
                end
                EMIT_V0: begin
                    if (vtx_hs) begin
                        vtx_out_q <= tri_q.v1;
                        vtx_idx_q <= 2'd1;
                        state_q   <= EMIT_V1;
                    end
                end
                EMIT_V1: begin
                    if (vtx_hs) begin
                        vtx_out_q  <= tri_q.v2;
                        vtx_idx_q  <= 2'd2;
                        vtx_last_q <= 1'b1;
                        state_q    <= EMIT_V2;
                    end
                end
                EMIT_V2: begin
                    if (vtx_hs) begin
                        vtx_valid_q <= 1'b0;
                        vtx_last_q  <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign vtx_valid     = vtx_valid_q;
    assign vtx_out       = vtx_out_q;
    assign vtx_idx       = vtx_idx_q;
    assign vtx_last      = vtx_last_q;
    assign model_out     = model_out_q;
    assign camera_out    = camera_out_q;
    assign camera_loaded = camera_loaded_q;
    assign err_no_cam    = err_q;

`ifdef SEQ_STATS_EN
    logic [CNT_W-1:0] tri_count_q;

    // Saturating count of completed triangles; frame_clear restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            tri_count_q <= '0;
        end else if (frame_clear) begin
            tri_count_q <= '0;
        end else if ((state_q == EMIT_V2) && vtx_hs && (tri_count_q != {CNT_W{1'b1}})) begin
            tri_count_q <= tri_count_q + CNT_W'(1);
        end
    end

    assign tri_count = tri_count_q;
`else
    assign tri_count = '0;
`endif

endmodule

// File: tb/tb_transform_vertex_sequencer.sv
// Directed bench for transform_vertex_sequencer with a queue-based reference model checked every cycle.
module tb_transform_vertex_sequencer;
    import transform_vertex_sequencer_pkg::*;

`ifdef SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        vertex_t    v;
        logic [1:0] idx;
        transform_t m;
        transform_t c;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    transform_setup_t setup_in = '0;
    logic             frame_clear = 1'b0;
    logic             vtx_valid;
    logic             vtx_ready = 1'b1;
    vertex_t          vtx_out;
    logic [1:0]       vtx_idx;
    logic             vtx_last;
    transform_t       model_out;
    transform_t       camera_out;
    logic             camera_loaded;
    logic             err_no_cam;
    logic [15:0]      tri_count;

    transform_vertex_sequencer #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .setup_in(setup_in), .frame_clear(frame_clear),
        .vtx_valid(vtx_valid), .vtx_ready(vtx_ready), .vtx_out(vtx_out),
        .vtx_idx(vtx_idx), .vtx_last(vtx_last), .model_out(model_out),
        .camera_out(camera_out), .camera_loaded(camera_loaded),
        .err_no_cam(err_no_cam), .tri_count(tri_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t        q[$];
    transform_t  cam_m    = '0;
    logic        loaded_m = 1'b0;
    logic        err_m    = 1'b0;
    logic [15:0] tri_m    = '0;

    logic [11:0] log_color[$];
    logic [1:0]  log_idx[$];
    logic        log_last[$];
    transform_t  log_cam[$];
    int          log_cyc[$];

    task automatic check(input string nm, input logic [191:0] a, input logic [191:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    function automatic vertex_t mk_v(input logic [11:0] c);
        vertex_t v;
        v.x = 16'(c) + 16'h1000;
        v.y = 16'(c) + 16'h2000;
        v.z = 16'(c) + 16'h3000;
        v.color = c;
        return v;
    endfunction

    function automatic transform_t mk_xf(input logic [15:0] b);
        transform_t t;
        for (int i = 0; i < 12; i++) t.m[i] = b + 16'(i);
        return t;
    endfunction

    function automatic transform_setup_t mk_beat(input logic cv, input transform_t c,
                                                 input logic mv, input transform_t m,
                                                 input logic [11:0] c0, input logic [11:0] c1,
                                                 input logic [11:0] c2);
        transform_setup_t b;
        b.camera_transform_valid = cv;
        b.camera_transform       = c;
        b.model_transform_valid  = mv;
        b.model_transform        = m;
        b.triangle.v0            = mk_v(c0);
        b.triangle.v1            = mk_v(c1);
        b.triangle.v2            = mk_v(c2);
        return b;
    endfunction

    // Compare current outputs with the model, then advance the model across the coming edge.
    task automatic monitor();
        exp_t e;
        logic cam_now;
        cyc++;
        check("in_ready", in_ready, !rst && (q.size() == 0));
        check("vtx_valid", vtx_valid, q.size() != 0);
        if (q.size() != 0) begin
            e = q[0];
            check("vtx_out", vtx_out, e.v);
            check("vtx_idx", vtx_idx, e.idx);
            check("vtx_last", vtx_last, e.idx == 2'd2);
            check("model_out", model_out, e.m);
            check("camera_out", camera_out, e.c);
        end
        check("camera_loaded", camera_loaded, loaded_m);
        check("err_no_cam", err_no_cam, err_m);
        check("tri_count", tri_count, tri_m);

        if (rst) begin
            q.delete();
            loaded_m = 1'b0;
            err_m    = 1'b0;
            tri_m    = '0;
            cam_m    = '0;
        end else begin
            if (q.size() != 0 && vtx_ready) begin
                e = q.pop_front();
                log_color.push_back(vtx_out.color);
                log_idx.push_back(vtx_idx);
                log_last.push_back(vtx_last);
                log_cam.push_back(camera_out);
                log_cyc.push_back(cyc);
                if (STATS && e.idx == 2'd2 && tri_m != 16'hFFFF) tri_m++;
            end
            if (in_valid && in_ready) begin
                cam_now = loaded_m || setup_in.camera_transform_valid;
                if (setup_in.camera_transform_valid) cam_m = setup_in.camera_transform;
                if (setup_in.model_transform_valid) begin
                    if (cam_now) begin
                        q.push_back('{setup_in.triangle.v0, 2'd0, setup_in.model_transform, cam_m});
                        q.push_back('{setup_in.triangle.v1, 2'd1, setup_in.model_transform, cam_m});
                        q.push_back('{setup_in.triangle.v2, 2'd2, setup_in.model_transform, cam_m});
                    end else begin
                        err_m = 1'b1;
                    end
                end
                if (setup_in.camera_transform_valid) loaded_m = 1'b1;
                else if (frame_clear) loaded_m = 1'b0;
            end else if (frame_clear) begin
                loaded_m = 1'b0;
            end
            if (STATS && frame_clear) tri_m = '0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic clear_log();
        log_color.delete(); log_idx.delete(); log_last.delete();
        log_cam.delete(); log_cyc.delete();
    endtask

    task automatic send(input transform_setup_t b);
        logic ok = 1'b0;
        setup_in = b;
        in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            ok = in_ready;
            tick();
            if (ok) break;
        end
        in_valid = 1'b0;
        setup_in = '0;
        check("send_accept", ok, 1'b1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 50; k++) begin
            if (in_ready) break;
            tick();
        end
        check("wait_idle", in_ready, 1'b1);
    endtask

    transform_t c1, c2, m1, m2;
    int         ret;

    initial begin
        c1 = mk_xf(16'h0100);
        c2 = mk_xf(16'h0200);
        m1 = mk_xf(16'h0A00);
        m2 = mk_xf(16'h0B00);

        // Reset values
        do_reset();
        rst = 1'b1;
        tick();
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_vtx_valid", vtx_valid, 1'b0);
        check("rst_vtx_out", vtx_out, '0);
        check("rst_camera_out", camera_out, '0);
        check("rst_tri_count", tri_count, '0);
        rst = 1'b0;
        tick();

        // Camera then one triangle, full throughput
        clear_log();
        send(mk_beat(1'b1, c1, 1'b0, m1, 12'h0, 12'h0, 12'h0));
        check("cam_loaded_lit", camera_loaded, 1'b1);
        send(mk_beat(1'b0, c2, 1'b1, m1, 12'h111, 12'h222, 12'h333));
        ret = 1;
        while (!in_ready && ret < 20) begin
            tick();
            ret++;
        end
        check("in_ready_return", ret, 4);
        check("log_n", log_color.size(), 3);
        if (log_color.size() == 3) begin
            check("col0", log_color[0], 12'h111);
            check("col1", log_color[1], 12'h222);
            check("col2", log_color[2], 12'h333);
            check("idx2", log_idx[2], 2'd2);
            check("last0", log_last[0], 1'b0);
            check("last1", log_last[1], 1'b0);
            check("last2", log_last[2], 1'b1);
            check("cam_lit", log_cam[1], c1);
            check("gap01", log_cyc[1] - log_cyc[0], 1);
            check("gap12", log_cyc[2] - log_cyc[1], 1);
        end

        // Backpressure for 5 cycles on vertex 1
        clear_log();
        send(mk_beat(1'b0, c2, 1'b1, m2, 12'h444, 12'h555, 12'h666));
        tick();
        vtx_ready = 1'b0;
        repeat (5) tick();
        vtx_ready = 1'b1;
        wait_idle();
        check("bp_log_n", log_color.size(), 3);
        if (log_color.size() == 3) begin
            check("bp_gap01", log_cyc[1] - log_cyc[0], 6);
            check("bp_gap12", log_cyc[2] - log_cyc[1], 1);
            check("bp_col1", log_color[1], 12'h555);
        end

        // Triangle with no camera is dropped; err stays sticky
        do_reset();
        clear_log();
        send(mk_beat(1'b0, c1, 1'b1, m1, 12'h777, 12'h888, 12'h999));
        tick();
        check("nocam_err", err_no_cam, 1'b1);
        check("nocam_in_ready", in_ready, 1'b1);
        check("nocam_no_beats", log_color.size(), 0);
        send(mk_beat(1'b1, c1, 1'b0, m1, 12'h0, 12'h0, 12'h0));
        send(mk_beat(1'b0, c1, 1'b1, m1, 12'h123, 12'h456, 12'h789));
        wait_idle();
        check("nocam_later_beats", log_color.size(), 3);
        check("nocam_err_sticky", err_no_cam, 1'b1);

        // Camera and model on the same beat
        clear_log();
        send(mk_beat(1'b1, c2, 1'b1, m2, 12'h0AA, 12'h0BB, 12'h0CC));
        wait_idle();
        check("same_n", log_cam.size(), 3);
        if (log_cam.size() == 3) begin
            check("same_cam0", log_cam[0], c2);
            check("same_cam2", log_cam[2], c2);
        end

        // frame_clear during vertex 0
        do_reset();
        clear_log();
        send(mk_beat(1'b1, c1, 1'b0, m1, 12'h0, 12'h0, 12'h0));
        send(mk_beat(1'b0, c2, 1'b1, m1, 12'hABC, 12'hBCD, 12'hCDE));
        frame_clear = 1'b1;
        tick();
        frame_clear = 1'b0;
        wait_idle();
        check("fc_n", log_cam.size(), 3);
        if (log_cam.size() == 3) check("fc_old_cam", log_cam[2], c1);
        check("fc_cam_loaded", camera_loaded, 1'b0);
        check("fc_err_before", err_no_cam, 1'b0);
        send(mk_beat(1'b0, c1, 1'b1, m1, 12'h1, 12'h2, 12'h3));
        tick();
        check("fc_err_after", err_no_cam, 1'b1);
        check("fc_no_more", log_cam.size(), 3);

        // Statistics counter
        do_reset();
        send(mk_beat(1'b1, c1, 1'b0, m1, 12'h0, 12'h0, 12'h0));
        for (int t = 0; t < 3; t++) begin
            send(mk_beat(1'b0, c1, 1'b1, m2, 12'(t), 12'(t + 1), 12'(t + 2)));
            wait_idle();
        end
        tick();
        check("stats_three", tri_count, STATS ? 16'd3 : 16'd0);
        frame_clear = 1'b1;
        tick();
        frame_clear = 1'b0;
        tick();
        check("stats_cleared", tri_count, 16'd0);

        // Reset mid-emission aborts the triangle
        do_reset();
        send(mk_beat(1'b1, c1, 1'b1, m1, 12'hF1, 12'hF2, 12'hF3));
        vtx_ready = 1'b0;
        tick();
        clear_log();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vtx_ready = 1'b1;
        repeat (4) tick();
        check("abort_no_beats", log_color.size(), 0);
        check("abort_idle", in_ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/transform_vertex_sequencer.md
# transform_vertex_sequencer

Sits directly downstream of the frame driver and consumes its `transform_setup_t` beats through a valid/ready handshake. Holds the current camera transform and the current model transform plus triangle. Emits each triangle as three vertex beats, each paired with the model and camera transforms, to the vertex transform pipeline. Camera-only beats update state and emit nothing.

## Interface
Parameters:
- `CNT_W`, 16: width of the triangle statistics counter.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: a setup beat is present on `setup_in`.
- `in_ready` out 1: the block accepts a beat this cycle.
- `setup_in` in `transform_setup_t`: the fields used are `triangle.v0/v1/v2`, `model_transform`, `model_transform_valid`, `camera_transform` and `camera_transform_valid`.
- `frame_clear` in 1: a one-cycle pulse that invalidates the held camera.
- `vtx_valid` out 1: a vertex beat is present.
- `vtx_ready` in 1: the downstream stage accepts the vertex beat.
- `vtx_out` out `vertex_t`: the current vertex.
- `vtx_idx` out 2: the vertex index within the triangle (0, 1 or 2).
- `vtx_last` out 1: high on the `vtx_idx==2` beat.
- `model_out` out `transform_t`: the model transform for this vertex.
- `camera_out` out `transform_t`: the camera transform for this vertex.
- `camera_loaded` out 1: a camera transform is currently held.
- `err_no_cam` out 1: sticky flag; a triangle arrived while no camera was held.
- `tri_count` out `CNT_W`: count of triangles fully emitted (see Configuration).

## Operation
- The state machine has four states: `IDLE`, `EMIT_V0`, `EMIT_V1`, `EMIT_V2`.
- `in_ready = (state==IDLE) && !rst`. This is combinational; no other path asserts it.
- When an input beat is accepted in `IDLE` (`in_valid && in_ready`):
  - If `camera_transform_valid`: latch `camera_transform` into the camera register and set `camera_loaded`=1.
  - If `model_transform_valid` and the camera is held, or is being loaded on this same beat: latch `model_transform` and the triangle, then go to `EMIT_V0`.
  - If `model_transform_valid` and no camera is held or being loaded: drop the triangle, set `err_no_cam`=1, stay in `IDLE`.
  - If neither valid flag is set: consume the beat and ignore it.
- Camera and model valid on the same beat: the camera is latched first, and the triangle uses the new camera.
- Emit states:
  - `EMIT_Vn` drives `vtx_valid`=1, `vtx_out`=vn, `vtx_idx`=n, `vtx_last`=(n==2), `model_out` = latched model, `camera_out` = latched camera.
  - Advance to the next state only on `vtx_valid && vtx_ready`.
  - `EMIT_V2` returns to `IDLE` on handshake and increments `tri_count` (when enabled).
- `vtx_valid` must not drop, and output data must not change, while `vtx_ready`=0.
- Camera and model registers change only in `IDLE`, so the transforms are constant across all three vertices of a triangle.
- `frame_clear`:
  - Clears `camera_loaded` on the next edge; the camera register contents are kept.
  - If it arrives mid-emission, the current triangle completes with the latched camera.
  - If it coincides with a camera-valid accept, the accept wins and `camera_loaded` ends at 1.
- `err_no_cam` is cleared only by `rst`.
- `rst` mid-emission aborts the triangle: no further vertex beats are emitted, and the state returns to `IDLE`.

## Timing
- Reset values:
  - State `IDLE`.
  - `vtx_valid`, `vtx_last`, `vtx_idx`, `camera_loaded`, `err_no_cam`, `tri_count` all 0.
  - `vtx_out`, `model_out`, `camera_out` all zero.
  - `in_ready`=0 while `rst`=1.
- All outputs except `in_ready` come from registers.
- Latency: triangle accepted at edge N gives `vtx_valid`=1 in cycle N+1 with `vtx_idx`=0.
- With `vtx_ready` held high, vertices 0, 1, 2 appear in cycles N+1, N+2, N+3, and `in_ready` returns in cycle N+4.
- Peak throughput is one triangle per 4 cycles.
- Camera-only beats are accepted back-to-back, one per cycle.
- The `camera_loaded` update is visible one cycle after the accepting edge.

## Configuration
- `SEQ_STATS_EN`:
  - Defined: `tri_count` increments on each `EMIT_V2` handshake and saturates at 2^`CNT_W`−1. `frame_clear` resets it to 0.
  - Undefined: no counter logic is built, `tri_count` is tied to 0, and the port list is unchanged.

## Test plan
- Camera beat, then one triangle (v0/v1/v2 colors 0x111/0x222/0x333), `vtx_ready`=1:
  - Three beats on consecutive cycles with colors 0x111, 0x222, 0x333.
  - `vtx_idx` 0, 1, 2; `vtx_last` only on the third beat.
  - `camera_out` equals the camera transform sent.
  - `in_ready` returns 4 cycles after the triangle accept.
- Backpressure: `vtx_ready`=0 for 5 cycles during `EMIT_V1` → `vtx_valid` held and `vtx_out`/`vtx_idx`=1 stable. Release → v2 follows on the next cycle.
- Triangle with no camera ever loaded → no vertex beat, `err_no_cam`=1, `in_ready` stays 1. A later camera plus triangle emits normally, and `err_no_cam` stays 1.
- Camera and model valid on the same beat with camera C2 (C1 previously loaded) → all three vertex beats carry `camera_out`=C2.
- `frame_clear` during `EMIT_V0` → the triangle completes with the old camera and `camera_loaded`=0 afterwards. The next triangle is dropped with `err_no_cam`=1.
- With `SEQ_STATS_EN`: 3 triangles gives `tri_count`=3, then `frame_clear` gives 0. Without `SEQ_STATS_EN`: `tri_count` reads 0 throughout.
